mdio_access_arbiter: RTL and testbench

- Owns the single EthernetMDIOTransceiver command port on the management PHY; shares it between the host register path and an autonomous link-status poller.
- The poller reads the PHY basic status register (BMSR) periodically, so link state is tracked without software load.
- Sits in the management subsystem between the register interface and the MDIO transceiver, in the sys_clk domain.

---
 rtl/mdio_access_arbiter_pkg.sv | 7 +
 rtl/mdio_access_arbiter_if.sv | 19 +
 rtl/mdio_access_arbiter_poll_timer.sv | 23 ++
 rtl/mdio_access_arbiter.sv | 217 +++++++++++++++++++++
 tb/tb_mdio_access_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mdio_access_arbiter_pkg.sv
// Shared types for the MDIO access arbiter: FSM states, grant owners, BMSR bit positions.
package MdioArbTypes;
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_START, WAIT_DONE} mdio_arb_state_t;
   typedef enum logic {OWNER_HOST, OWNER_POLL} mdio_owner_t;
   localparam int BMSR_LINK_BIT = 2;
   localparam int BMSR_ANEG_BIT = 5;
endpackage

// File: rtl/mdio_access_arbiter_if.sv
// Command port to the MDIO transceiver; master issues register strobes, slave reports busy/data.
interface mdio_access_arbiter_if;
   logic [4:0]  phy_md_addr;
   logic [4:0]  phy_reg_addr;
   logic [15:0] phy_wr_data;
   logic        phy_reg_rd;
   logic        phy_reg_wr;
   logic        mdio_busy;
   logic [15:0] phy_rd_data;

   modport master (
      output phy_md_addr, phy_reg_addr, phy_wr_data, phy_reg_rd, phy_reg_wr,
      input  mdio_busy, phy_rd_data
   );
   modport slave (
      input  phy_md_addr, phy_reg_addr, phy_wr_data, phy_reg_rd, phy_reg_wr,
      output mdio_busy, phy_rd_data
   );
endinterface

// File: rtl/mdio_access_arbiter_poll_timer.sv
// Poll interval counter: o_tc is a combinational pulse on the last count; no backpressure.
// poll_en low holds the count at zero.
module mdio_poll_timer #(
   parameter int POLL_INTERVAL = 25000000
) (
   input  logic clk,
   input  logic rst,
   input  logic i_poll_en,
   output logic o_tc
);
   localparam int W = (POLL_INTERVAL > 2) ? $clog2(POLL_INTERVAL) : 1;

   logic [W-1:0] r_cnt;
   logic         w_last;

   assign w_last = (r_cnt == W'(POLL_INTERVAL - 1));
   assign o_tc   = i_poll_en && w_last;

   always_ff @(posedge clk) begin
      if (rst || !i_poll_en || w_last) r_cnt <= '0;
      else                             r_cnt <= r_cnt + W'(1);
   end
endmodule

// File: rtl/mdio_access_arbiter.sv
// Shares the MDIO transceiver between host requests and a BMSR link poller; strobe 2 cycles after a
// host request, one request held, extras dropped with host_overrun. Option: MDIO_ARB_TIMEOUT_EN.
module mdio_access_arbiter
   import MdioArbTypes::*;
#(
   parameter int         POLL_INTERVAL  = 25000000,
   parameter logic [4:0] POLL_REG       = 5'd1
`ifdef MDIO_ARB_TIMEOUT_EN
   , parameter int       TIMEOUT_CYCLES = 65535
`endif
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        host_rd,
   input  logic        host_wr,
   input  logic [4:0]  host_md_addr,
   input  logic [4:0]  host_reg_addr,
   input  logic [15:0] host_wr_data,
   output logic        host_busy,
   output logic        host_done,
   output logic [15:0] host_rd_data,
   output logic        host_overrun,
   input  logic        poll_en,
   input  logic [4:0]  poll_md_addr,
   output logic        link_up,
   output logic        an_complete,
   output logic        status_valid,
   output logic        link_change,
`ifdef MDIO_ARB_TIMEOUT_EN
   output logic        mdio_timeout,
`endif
   mdio_access_arbiter_if.master phy
);
   mdio_arb_state_t r_state, w_next_state;
   mdio_owner_t     r_owner, r_last_grant, w_grant_owner;

   logic        w_grant, w_complete, w_timeout, w_poll_tc;
   logic        w_host_elig, w_poll_elig, w_issue_rd, w_issue_wr, w_poll_inflight;
   logic        r_host_pending, r_poll_pending;
   logic        r_hold_wr;
   logic [4:0]  r_hold_md, r_hold_reg;
   logic [15:0] r_hold_wd;
   logic        r_is_wr;
   logic [4:0]  r_phy_md, r_phy_reg;
   logic [15:0] r_phy_wd;
   logic        r_host_done, r_host_overrun, r_link_up, r_an_complete, r_status_valid, r_link_change;
   logic [15:0] r_host_rd_data;

   mdio_poll_timer #(.POLL_INTERVAL(POLL_INTERVAL)) u_poll_timer (
      .clk       (clk),
      .rst       (rst),
      .i_poll_en (poll_en),
      .o_tc      (w_poll_tc)
   );

   // A pending poll is withdrawn while poll_en is low, so it is not eligible for a grant either.
   assign w_host_elig     = r_host_pending;
   assign w_poll_elig     = r_poll_pending && poll_en;
   assign w_poll_inflight = (r_state != IDLE) && (r_owner == OWNER_POLL);

`ifdef MDIO_ARB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] r_to_cnt;
   logic          r_mdio_timeout;
   logic          w_waiting;

   assign w_waiting    = (r_state == WAIT_START) || (r_state == WAIT_DONE);
   assign w_timeout    = w_waiting && (r_to_cnt == TW'(TIMEOUT_CYCLES));
   assign mdio_timeout = r_mdio_timeout;

   always_ff @(posedge clk) begin
      if (rst || !w_waiting) r_to_cnt <= '0;
      else if (!w_timeout)   r_to_cnt <= r_to_cnt + TW'(1);
      if (rst)               r_mdio_timeout <= 1'b0;
      else if (w_timeout)    r_mdio_timeout <= 1'b1;
   end
`else
   assign w_timeout = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next_state;
   end

   always_comb begin
      w_next_state  = r_state;
      w_grant       = 1'b0;
      w_grant_owner = OWNER_HOST;
      w_issue_rd    = 1'b0;
      w_issue_wr    = 1'b0;
      w_complete    = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_host_elig && w_poll_elig) begin
               w_grant       = 1'b1;
               w_grant_owner = (r_last_grant == OWNER_HOST) ? OWNER_POLL : OWNER_HOST;
            end else if (w_host_elig) begin
               w_grant = 1'b1;
            end else if (w_poll_elig) begin
               w_grant       = 1'b1;
               w_grant_owner = OWNER_POLL;
            end
            if (w_grant) w_next_state = ISSUE;
         end
         ISSUE: begin
            w_issue_wr   = r_is_wr;
            w_issue_rd   = !r_is_wr;
            w_next_state = WAIT_START;
         end
         WAIT_START: begin
            if (w_timeout) begin
               w_complete   = 1'b1;
               w_next_state = IDLE;
            end else if (phy.mdio_busy) begin
               w_next_state = WAIT_DONE;
            end
         end
         WAIT_DONE: begin
            if (!phy.mdio_busy || w_timeout) begin
               w_complete   = 1'b1;
               w_next_state = IDLE;
            end
         end
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_host_pending <= 1'b0;
         r_poll_pending <= 1'b0;
         r_hold_wr      <= 1'b0;
         r_hold_md      <= '0;
         r_hold_reg     <= '0;
         r_hold_wd      <= '0;
         r_owner        <= OWNER_HOST;
         r_last_grant   <= OWNER_POLL;
         r_is_wr        <= 1'b0;
         r_phy_md       <= '0;
         r_phy_reg      <= '0;
         r_phy_wd       <= '0;
         r_host_done    <= 1'b0;
         r_host_overrun <= 1'b0;
         r_host_rd_data <= '0;
         r_link_up      <= 1'b0;
         r_an_complete  <= 1'b0;
         r_status_valid <= 1'b0;
         r_link_change  <= 1'b0;
      end else begin
         r_host_done    <= 1'b0;
         r_host_overrun <= 1'b0;
         r_link_change  <= 1'b0;

         if (host_rd || host_wr) begin
            if (r_host_pending) begin
               r_host_overrun <= 1'b1;
            end else begin
               r_host_pending <= 1'b1;
               r_hold_wr      <= host_wr;
               r_hold_md      <= host_md_addr;
               r_hold_reg     <= host_reg_addr;
               r_hold_wd      <= host_wr_data;
            end
         end

         if (w_grant) begin
            r_owner      <= w_grant_owner;
            r_last_grant <= w_grant_owner;
            if (w_grant_owner == OWNER_HOST) begin
               r_is_wr   <= r_hold_wr;
               r_phy_md  <= r_hold_md;
               r_phy_reg <= r_hold_reg;
               r_phy_wd  <= r_hold_wd;
            end else begin
               r_is_wr   <= 1'b0;
               r_phy_md  <= poll_md_addr;
               r_phy_reg <= POLL_REG;
               r_phy_wd  <= '0;
            end
         end

         if (w_complete && r_owner == OWNER_HOST) begin
            r_host_pending <= 1'b0;
            r_host_done    <= 1'b1;
            if (w_timeout)     r_host_rd_data <= 16'hFFFF;
            else if (!r_is_wr) r_host_rd_data <= phy.phy_rd_data;
         end

         if (w_complete && r_owner == OWNER_POLL) begin
            r_poll_pending <= 1'b0;
            if (!w_timeout) begin
               r_link_up      <= phy.phy_rd_data[BMSR_LINK_BIT];
               r_an_complete  <= phy.phy_rd_data[BMSR_ANEG_BIT];
               r_status_valid <= 1'b1;
               r_link_change  <= r_status_valid && (phy.phy_rd_data[BMSR_LINK_BIT] != r_link_up);
            end
         end
         if (!poll_en && !w_poll_inflight) r_poll_pending <= 1'b0;
         if (w_poll_tc)                    r_poll_pending <= 1'b1;
      end
   end

   assign host_busy        = r_host_pending;
   assign host_done        = r_host_done;
   assign host_rd_data     = r_host_rd_data;
   assign host_overrun     = r_host_overrun;
   assign link_up          = r_link_up;
   assign an_complete      = r_an_complete;
   assign status_valid     = r_status_valid;
   assign link_change      = r_link_change;
   assign phy.phy_md_addr  = r_phy_md;
   assign phy.phy_reg_addr = r_phy_reg;
   assign phy.phy_wr_data  = r_phy_wd;
   assign phy.phy_reg_rd   = w_issue_rd;
   assign phy.phy_reg_wr   = w_issue_wr;
endmodule

// File: tb/tb_mdio_access_arbiter.sv
// Bench for mdio_access_arbiter: a register-file PHY model answers strobes; expectations come from
// a shadow register map, latency formulas and the grant/BMSR rules.
module tb_mdio_access_arbiter;
   localparam int         PI      = 100;
   localparam logic [4:0] PREG    = 5'd1;
   localparam logic [4:0] POLL_MD = 5'd0;

   logic        clk = 1'b0;
   logic        rst;
   logic        host_rd, host_wr;
   logic [4:0]  host_md_addr, host_reg_addr;
   logic [15:0] host_wr_data;
   logic        host_busy, host_done, host_overrun;
   logic [15:0] host_rd_data;
   logic        poll_en;
   logic [4:0]  poll_md_addr;
   logic        link_up, an_complete, status_valid, link_change;
`ifdef MDIO_ARB_TIMEOUT_EN
   logic        mdio_timeout;
`endif

   always #5 clk = ~clk;

   mdio_access_arbiter_if phy_bus ();

   mdio_access_arbiter #(
      .POLL_INTERVAL (PI),
      .POLL_REG      (PREG)
`ifdef MDIO_ARB_TIMEOUT_EN
      , .TIMEOUT_CYCLES (50)
`endif
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .host_rd       (host_rd),
      .host_wr       (host_wr),
      .host_md_addr  (host_md_addr),
      .host_reg_addr (host_reg_addr),
      .host_wr_data  (host_wr_data),
      .host_busy     (host_busy),
      .host_done     (host_done),
      .host_rd_data  (host_rd_data),
      .host_overrun  (host_overrun),
      .poll_en       (poll_en),
      .poll_md_addr  (poll_md_addr),
      .link_up       (link_up),
      .an_complete   (an_complete),
      .status_valid  (status_valid),
      .link_change   (link_change),
`ifdef MDIO_ARB_TIMEOUT_EN
      .mdio_timeout  (mdio_timeout),
`endif
      .phy           (phy_bus)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          cyc;
      bit          wr;
      logic [4:0]  md;
      logic [4:0]  rg;
      logic [15:0] wd;
   } strobe_t;

   logic [15:0] phy_regs [32];
   logic [15:0] exp_regs [32];
   logic [15:0] exp_rd;
   int          busy_len = 5;
   bit          no_busy  = 1'b0;
   bit          hold_chk = 1'b1;
   int          hold_err = 0;
   strobe_t     slog [$];
   int          done_q [$];
   logic [15:0] done_dat_q [$];
   bit          done_busy_q [$];
   int          ovr_q [$];
   int          lchg_q [$];

   // PHY model: a 32-entry register file that goes busy the cycle after a strobe.
   initial begin
      phy_bus.mdio_busy   = 1'b0;
      phy_bus.phy_rd_data = 16'h0;
      forever begin
         @(negedge clk);
         if (phy_bus.phy_reg_rd || phy_bus.phy_reg_wr) begin
            strobe_t s;
            s.cyc = cyc;
            s.wr  = phy_bus.phy_reg_wr;
            s.md  = phy_bus.phy_md_addr;
            s.rg  = phy_bus.phy_reg_addr;
            s.wd  = phy_bus.phy_wr_data;
            slog.push_back(s);
            if (s.wr) phy_regs[s.rg] = s.wd;
            else      phy_bus.phy_rd_data = phy_regs[s.rg];
            if (!no_busy) begin
               @(negedge clk);
               phy_bus.mdio_busy = 1'b1;
               for (int k = 0; k < busy_len; k++) begin
                  if (k > 0) @(negedge clk);
                  if (hold_chk && {phy_bus.phy_md_addr, phy_bus.phy_reg_addr, phy_bus.phy_wr_data}
                                  !== {s.md, s.rg, s.wd}) hold_err++;
               end
               @(negedge clk);
               phy_bus.mdio_busy = 1'b0;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (host_done) begin
         done_q.push_back(cyc);
         done_dat_q.push_back(host_rd_data);
         done_busy_q.push_back(host_busy);
      end
      if (host_overrun) ovr_q.push_back(cyc);
      if (link_change)  lchg_q.push_back(cyc);
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic clear_logs();
      slog.delete(); done_q.delete(); done_dat_q.delete(); done_busy_q.delete();
      ovr_q.delete(); lchg_q.delete(); hold_err = 0;
   endtask

   task automatic set_phy_reg(input logic [4:0] a, input logic [15:0] v);
      phy_regs[a] = v;
      exp_regs[a] = v;
   endtask

   task automatic host_req(input bit rd, input bit wr, input logic [4:0] md, input logic [4:0] rg,
                           input logic [15:0] wd);
      host_rd = rd; host_wr = wr; host_md_addr = md; host_reg_addr = rg; host_wr_data = wd;
      @(negedge clk);
      host_rd = 1'b0; host_wr = 1'b0;
   endtask

   function automatic logic [63:0] outs_vec();
      return {13'd0, host_busy, host_done, host_rd_data, host_overrun, link_up, an_complete,
              status_valid, link_change, phy_bus.phy_md_addr, phy_bus.phy_reg_addr,
              phy_bus.phy_wr_data, phy_bus.phy_reg_rd, phy_bus.phy_reg_wr};
   endfunction

   function automatic byte owner_of(input strobe_t s);
      return (!s.wr && s.md == POLL_MD && s.rg == PREG) ? "P" : "H";
   endfunction

   // One host transaction to an idle arbiter: strobe at +2, done at +len+4 relative to the request.
   task automatic host_txn(input string tag, input bit rd, input bit wr, input logic [4:0] md,
                           input logic [4:0] rg, input logic [15:0] wd, input int len);
      int c0;
      clear_logs();
      busy_len = len;
      c0 = cyc;
      host_req(rd, wr, md, rg, wd);
      tick(len + 8);
      if (wr) exp_regs[rg] = wd;
      else    exp_rd = exp_regs[rg];
      chk({tag, "_nstrobe"}, slog.size(), 1);
      if (slog.size() > 0) begin
         chk({tag, "_strobe_cyc"}, slog[0].cyc - c0, 2);
         chk({tag, "_strobe_cmd"}, {slog[0].wr, slog[0].md, slog[0].rg}, {wr, md, rg});
         if (wr) chk({tag, "_strobe_wd"}, slog[0].wd, wd);
      end
      chk({tag, "_ndone"}, done_q.size(), 1);
      if (done_q.size() > 0) begin
         chk({tag, "_done_cyc"}, done_q[0] - c0, len + 4);
         chk({tag, "_rd_data"}, done_dat_q[0], exp_rd);
         chk({tag, "_busy_at_done"}, done_busy_q[0], 1'b0);
      end
      chk({tag, "_addr_hold"}, hold_err, 0);
   endtask

   initial begin
      int          c0;
      logic [15:0] bmsr;
      rst = 1'b1; host_rd = 1'b0; host_wr = 1'b0; host_md_addr = '0; host_reg_addr = '0;
      host_wr_data = '0; poll_en = 1'b0; poll_md_addr = POLL_MD;
      exp_rd = 16'h0;
      for (int i = 0; i < 32; i++) set_phy_reg(5'(i), 16'($urandom));

      tick(3);
      chk("reset_outputs", outs_vec(), 64'd0);
      rst = 1'b0;
      tick(2);

      set_phy_reg(5'd7, 16'h796D);
      host_txn("host_read", 1'b1, 1'b0, 5'h11, 5'd7, 16'h0, 40);
      host_txn("host_write_r0", 1'b0, 1'b1, 5'h11, 5'd0, 16'h1200, 40);
      chk("phy_r0_written", phy_regs[0], 16'h1200);
      chk("rd_data_kept_after_write", host_rd_data, 16'h796D);

      for (int t = 0; t < 6; t++) begin
         int sel;
         sel = $urandom_range(0, 2);
         host_txn($sformatf("rand%0d", t), sel != 1, sel != 0, 5'($urandom_range(1, 31)),
                  5'($urandom_range(0, 31)), 16'($urandom), $urandom_range(1, 20));
      end

      // Poller: first BMSR read sets status only; second one raises link and pulses link_change.
      bmsr = 16'h7949;
      set_phy_reg(PREG, bmsr);
      clear_logs();
      busy_len = 5;
      c0 = cyc;
      poll_en = 1'b1;
      tick(120);
      chk("poll1_nstrobe", slog.size(), 1);
      if (slog.size() > 0) begin
         chk("poll1_cyc", slog[0].cyc - c0, PI + 1);
         chk("poll1_cmd", {slog[0].wr, slog[0].md, slog[0].rg}, {1'b0, POLL_MD, PREG});
      end
      chk("poll1_valid", status_valid, 1'b1);
      chk("poll1_link", link_up, bmsr[2]);
      chk("poll1_aneg", an_complete, bmsr[5]);
      chk("poll1_no_change", lchg_q.size(), 0);
      bmsr = 16'h796D;
      set_phy_reg(PREG, bmsr);
      tick(110);
      poll_en = 1'b0;
      chk("poll2_nstrobe", slog.size(), 2);
      if (slog.size() > 1) chk("poll2_interval", slog[1].cyc - slog[0].cyc, PI);
      chk("poll2_link", link_up, bmsr[2]);
      chk("poll2_aneg", an_complete, bmsr[5]);
      chk("poll2_change_once", lchg_q.size(), 1);
      chk("poll_no_host_done", done_q.size(), 0);

      // Host and poll pending together after a poll grant: host, then poll, then the later host.
      tick(2);
      clear_logs();
      busy_len = 5;
      c0 = cyc;
      poll_en = 1'b1;
      tick(PI - 1);
      host_req(1'b1, 1'b0, 5'h12, 5'd3, 16'h0);
      for (int k = 0; k < 60 && done_q.size() == 0; k++) @(negedge clk);
      host_req(1'b1, 1'b0, 5'h13, 5'd4, 16'h0);
      tick(40);
      poll_en = 1'b0;
      chk("grant_nstrobe", slog.size(), 3);
      if (slog.size() == 3)
         chk("grant_order", {owner_of(slog[0]), owner_of(slog[1]), owner_of(slog[2])}, "HPH");
      chk("grant_ndone", done_q.size(), 2);
      chk("grant_ovr", ovr_q.size(), 0);
      chk("grant_no_link_change", lchg_q.size(), 0);

      // Second request while busy is dropped; the first completes untouched.
      set_phy_reg(5'd9, 16'($urandom));
      clear_logs();
      busy_len = 30;
      host_req(1'b1, 1'b0, 5'h0A, 5'd9, 16'h0);
      tick(4);
      host_req(1'b0, 1'b1, 5'h0A, 5'd9, 16'hDEAD ^ exp_regs[9]);
      tick(45);
      chk("ovr_count", ovr_q.size(), 1);
      chk("ovr_nstrobe", slog.size(), 1);
      chk("ovr_ndone", done_q.size(), 1);
      if (done_dat_q.size() > 0) chk("ovr_rd_data", done_dat_q[0], exp_regs[9]);
      chk("ovr_reg_untouched", phy_regs[9], exp_regs[9]);

      // Reset while waiting for the transceiver to finish.
      clear_logs();
      hold_chk = 1'b0;
      busy_len = 30;
      host_req(1'b1, 1'b0, 5'h05, 5'd2, 16'h0);
      tick(9);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_wait_outputs", outs_vec(), 64'd0);
      rst = 1'b0;
      exp_rd = 16'h0;
      tick(40);
      for (int k = 0; k < 60 && phy_bus.mdio_busy; k++) @(negedge clk);
      chk("rst_no_done", done_q.size(), 0);
      hold_chk = 1'b1;
      tick(2);
      host_txn("post_rst", 1'b1, 1'b0, 5'h06, 5'd2, 16'h0, 3);

`ifdef MDIO_ARB_TIMEOUT_EN
      clear_logs();
      no_busy = 1'b1;
      c0 = cyc;
      host_req(1'b1, 1'b0, 5'h07, 5'd5, 16'h0);
      tick(70);
      chk("to_ndone", done_q.size(), 1);
      if (done_q.size() > 0) begin
         chk("to_done_cyc", done_q[0] - c0, 54);
         chk("to_rd_data", done_dat_q[0], 16'hFFFF);
      end
      chk("to_sticky", mdio_timeout, 1'b1);
      no_busy = 1'b0;
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
